fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Per-transform stage scheduler for the mixed-radix FFT datapath.
- On a start request for a size index, reads the per-radix power counts from the power lookup table, one radix per cycle, in radix order 4, 2, 3, 5.
- Emits one stage configuration per butterfly stage to the datapath over a valid/ready handshake, in that radix order.
- Each configuration carries the radix code, the stage index and the cumulative span.

Parameters:
- NUM_SIZES, 42, number of valid size indices; io_fftsize >= NUM_SIZES is an error.
- MAX_STAGES, 12, maximum total stages per transform; a larger power sum is an error.
- SPAN_W, 12, width of io_stage_span.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- io_start  in  1  request a new transform; sampled only in IDLE.
- io_fftsize  in  6  size index, captured with io_start.
- io_abort  in  1  cancel an in-progress transform.
- io_lut_fftsize  out  6  size index driven to the power LUT.
- io_lut_power  out  3  radix index to the LUT: 0=r4, 1=r2, 2=r3, 3=r5.
- io_lut_power4235  in  3  LUT result; combinational, same cycle.
- io_stage_valid  out  1  stage configuration valid.
- io_stage_ready  in  1  datapath accepts the stage.
- io_stage_radix  out  2  radix code, same encoding as io_lut_power.
- io_stage_idx  out  4  stage number, 0-based.
- io_stage_span  out  SPAN_W  product of all previously emitted radices; 1 for stage 0.
- io_stage_last  out  1  final stage of this transform.
- io_busy  out  1  high whenever the state is not IDLE.
- io_done  out  1  one-cycle pulse when a transform completes.
- io_err  out  1  one-cycle pulse when a request is rejected.
- io_stage_count  out  4  total stages of the last accepted transform; held until the next start.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except io_lut_fftsize=0 and io_lut_power=0; io_stage_count=0; power registers=0.
- Reset asserted mid-operation returns to IDLE next edge; no done or err pulse.
- States: IDLE, LOAD, CHECK, EMIT, DONE, ERR.
- IDLE:
  - io_start=1 with io_fftsize < NUM_SIZES: capture fftsize, clear cnt=0, go to LOAD.
  - io_start=1 with io_fftsize >= NUM_SIZES: go to ERR; no LUT read.
- LOAD:
  - Lasts 4 cycles, k=0..3.
  - Drives io_lut_fftsize=captured size and io_lut_power=k.
  - Registers io_lut_power4235 into pow[k] at the end of each cycle.
  - After k=3, go to CHECK.
- CHECK (1 cycle):
  - total = pow[0]+pow[1]+pow[2]+pow[3], computed 5 bits wide.
  - total > MAX_STAGES: go to ERR.
  - total == 0: io_stage_count=0, go to DONE.
  - Otherwise: io_stage_count=total, span=1, idx=0, cur radix = first k with pow[k] != 0, remaining = pow[cur]; go to EMIT.
- EMIT:
  - io_stage_valid=1.
  - Fields are stable while valid=1 and ready=0.
  - io_stage_last=1 when idx == total-1.
  - On the valid and ready cycle:
    - idx += 1.
    - span = (span * radix value {4,2,3,5}) truncated to SPAN_W bits.
    - remaining -= 1.
    - When remaining reaches 0, advance cur to the next k with nonzero pow.
  - Acceptance with last=1 goes to DONE.
  - Throughput: one stage per cycle when ready is held high.
- io_abort:
  - Effective in LOAD, CHECK and EMIT: go to IDLE next cycle.
  - valid drops immediately next cycle; no done pulse.
  - io_abort has priority over a simultaneous handshake.
  - Ignored in IDLE, DONE and ERR.
- DONE: io_done=1 for one cycle, then IDLE.
- ERR: io_err=1 for one cycle, then IDLE; io_stage_count is unchanged.
- io_start is ignored whenever the state is not IDLE.
- Timing:
  - Start accepted on cycle 0; LOAD occupies cycles 1-4; CHECK is cycle 5.
  - First io_stage_valid is on cycle 6.
  - With ready held high and N stages, io_done is on cycle 6+N.
- io_busy=1 in every state except IDLE, including DONE and ERR.

Test Plan:
- Bench LUT model gives pow={2,1,1,0}, start with fftsize=5, ready=1:
  - Stages: (r4, idx0, span1), (r4, idx1, span4), (r2, idx2, span16), (r3, idx3, span32, last=1).
  - io_done on cycle 10; io_stage_count=4.
- Same transform with ready toggling 1,0,0,1,...:
  - Fields hold steady during stalls.
  - Exactly 4 handshakes; spans identical to the ready=1 case.
- fftsize=42:
  - io_err pulses on cycle 1.
  - io_lut_power stays 0; no valid; io_stage_count is unchanged.
- Model pow={0,0,0,0}:
  - No valid asserted; io_done on cycle 6; io_stage_count=0.
- Model pow={5,4,3,1} (total 13):
  - io_err pulses; no stages emitted.
- Abort and reset:
  - Assert io_abort during the second EMIT handshake cycle: no done; idle next cycle; a new start is accepted the following cycle.
  - Assert reset in LOAD: all outputs 0 next cycle.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Stage scheduler for the mixed-radix FFT: reads per-radix power counts from the
// power LUT (order r4, r2, r3, r5) and streams one configuration per butterfly stage.
module fft_stage_sequencer #(
  parameter int NUM_SIZES  = 42,
  parameter int MAX_STAGES = 12,
  parameter int SPAN_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_start,
  input  logic [5:0]        io_fftsize,
  input  logic              io_abort,
  output logic [5:0]        io_lut_fftsize,
  output logic [2:0]        io_lut_power,
  input  logic [2:0]        io_lut_power4235,
  output logic              io_stage_valid,
  input  logic              io_stage_ready,
  output logic [1:0]        io_stage_radix,
  output logic [3:0]        io_stage_idx,
  output logic [SPAN_W-1:0] io_stage_span,
  output logic              io_stage_last,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_err,
  output logic [3:0]        io_stage_count,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a stage transfers on any cycle where io_stage_valid and io_stage_ready
  // are both high and io_abort is low; fields hold while valid waits for ready.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [6:0] NUM_SIZES_W  = 7'(NUM_SIZES);
  localparam logic [4:0] MAX_STAGES_W = 5'(MAX_STAGES);

  state_t            state_q, state_d;
  logic [5:0]        size_q, size_d;
  logic [1:0]        k_q, k_d;
  logic [2:0]        pow_q [4];
  logic [2:0]        pow_d [4];
  logic [4:0]        total_q, total_d;
  logic [3:0]        count_q, count_d;
  logic [SPAN_W-1:0] span_q, span_d;
  logic [3:0]        idx_q, idx_d;
  logic [1:0]        cur_q, cur_d;
  logic [2:0]        rem_q, rem_d;

  logic [4:0]        total_sum;
  logic [1:0]        first_nz;
  logic [1:0]        next_nz;
  logic [SPAN_W-1:0] radix_val;
  logic              is_emit;
  logic              is_load;
  logic              last_stage;

  assign is_emit    = (state_q == S_EMIT);
  assign is_load    = (state_q == S_LOAD);
  assign last_stage = ({1'b0, idx_q} == (total_q - 5'd1));

  always_comb begin
    total_sum = {2'b00, pow_q[0]} + {2'b00, pow_q[1]} + {2'b00, pow_q[2]} + {2'b00, pow_q[3]};
    first_nz  = 2'd0;
    next_nz   = cur_q;
    // Descending scan so the lowest qualifying radix index wins.
    for (int k = 3; k >= 0; k--) begin
      if (pow_q[k] != 3'd0) first_nz = 2'(k);
      if ((k > int'(cur_q)) && (pow_q[k] != 3'd0)) next_nz = 2'(k);
    end
    case (cur_q)
      2'd0:    radix_val = SPAN_W'(4);
      2'd1:    radix_val = SPAN_W'(2);
      2'd2:    radix_val = SPAN_W'(3);
      default: radix_val = SPAN_W'(5);
    endcase
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    k_d     = k_q;
    for (int i = 0; i < 4; i++) pow_d[i] = pow_q[i];
    total_d = total_q;
    count_d = count_q;
    span_d  = span_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (io_start) begin
          if ({1'b0, io_fftsize} < NUM_SIZES_W) begin
            size_d  = io_fftsize;
            k_d     = 2'd0;
            state_d = S_LOAD;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (io_abort) begin
          state_d = S_IDLE;
        end else begin
          pow_d[k_q] = io_lut_power4235;
          k_d        = k_q + 2'd1;
          if (k_q == 2'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (io_abort) begin
          state_d = S_IDLE;
        end else if (total_sum > MAX_STAGES_W) begin
          state_d = S_ERR;
        end else if (total_sum == 5'd0) begin
          count_d = 4'd0;
          state_d = S_DONE;
        end else begin
          count_d = total_sum[3:0];
          total_d = total_sum;
          span_d  = SPAN_W'(1);
          idx_d   = 4'd0;
          cur_d   = first_nz;
          rem_d   = pow_q[first_nz];
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (io_abort) begin
          state_d = S_IDLE;
        end else if (io_stage_ready) begin
          idx_d  = idx_q + 4'd1;
          span_d = span_q * radix_val;
          if (last_stage) begin
            state_d = S_DONE;
          end else if (rem_q == 3'd1) begin
            cur_d = next_nz;
            rem_d = pow_q[next_nz];
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      k_q     <= '0;
      for (int i = 0; i < 4; i++) pow_q[i] <= '0;
      total_q <= '0;
      count_q <= '0;
      span_q  <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      k_q     <= k_d;
      for (int i = 0; i < 4; i++) pow_q[i] <= pow_d[i];
      total_q <= total_d;
      count_q <= count_d;
      span_q  <= span_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
    end
  end

  assign io_lut_fftsize = is_load ? size_q : 6'd0;
  assign io_lut_power   = is_load ? {1'b0, k_q} : 3'd0;
  assign io_stage_valid = is_emit;
  assign io_stage_radix = is_emit ? cur_q : 2'd0;
  assign io_stage_idx   = is_emit ? idx_q : 4'd0;
  assign io_stage_span  = is_emit ? span_q : '0;
  assign io_stage_last  = is_emit && last_stage;
  assign io_busy        = (state_q != S_IDLE);
  assign io_done        = (state_q == S_DONE);
  assign io_err         = (state_q == S_ERR);
  assign io_stage_count = count_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized scoreboard bench for fft_stage_sequencer with a behavioural LUT and
// stage-list model; a negedge monitor pops expected stages on every handshake.
module tb_fft_stage_sequencer;

  localparam int SPAN_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_start;
  logic [5:0]        io_fftsize;
  logic              io_abort;
  logic [5:0]        io_lut_fftsize;
  logic [2:0]        io_lut_power;
  logic [2:0]        io_lut_power4235;
  logic              io_stage_valid;
  logic              io_stage_ready;
  logic [1:0]        io_stage_radix;
  logic [3:0]        io_stage_idx;
  logic [SPAN_W-1:0] io_stage_span;
  logic              io_stage_last;
  logic              io_busy;
  logic              io_done;
  logic              io_err;
  logic [3:0]        io_stage_count;
  logic [2:0]        dbg_state;

  fft_stage_sequencer #(.NUM_SIZES(42), .MAX_STAGES(12), .SPAN_W(SPAN_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .io_start         (io_start),
    .io_fftsize       (io_fftsize),
    .io_abort         (io_abort),
    .io_lut_fftsize   (io_lut_fftsize),
    .io_lut_power     (io_lut_power),
    .io_lut_power4235 (io_lut_power4235),
    .io_stage_valid   (io_stage_valid),
    .io_stage_ready   (io_stage_ready),
    .io_stage_radix   (io_stage_radix),
    .io_stage_idx     (io_stage_idx),
    .io_stage_span    (io_stage_span),
    .io_stage_last    (io_stage_last),
    .io_busy          (io_busy),
    .io_done          (io_done),
    .io_err           (io_err),
    .io_stage_count   (io_stage_count),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- LUT model ----------------
  logic [2:0] lut_tab [64][4];
  assign io_lut_power4235 = lut_tab[io_lut_fftsize][io_lut_power[1:0]];

  // ---------------- scoreboard state ----------------
  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [18:0] exp_q[$];
  int          exp_count = 0;
  int          rdy_mode  = 0;
  int          rdy_phase = 0;
  int          rv [4]    = '{4, 2, 3, 5};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- ready driver ----------------
  initial begin
    io_stage_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       io_stage_ready = 1'b1;
        1: begin
          io_stage_ready = (rdy_phase % 3 == 0);
          rdy_phase++;
        end
        default: io_stage_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic        prev_hold = 1'b0;
  logic [18:0] prev_fields;

  always @(negedge clk) begin
    logic [18:0] got;
    logic [18:0] e;
    got = {io_stage_radix, io_stage_idx, io_stage_span, io_stage_last};
    if (prev_hold) begin
      check("stall_valid", 32'(io_stage_valid), 32'd1);
      check("stall_fields", 32'(got), 32'(prev_fields));
    end
    prev_hold   = io_stage_valid && !io_stage_ready && !io_abort && !reset;
    prev_fields = got;
    if (!reset && !io_abort && io_stage_valid && io_stage_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_stage", 32'(got), 32'h7ffff);
      end else begin
        e = exp_q.pop_front();
        check("stage_fields", 32'(got), 32'(e));
      end
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic model(input int size, output bit is_err, output int n, output int err_cyc);
    int total;
    int span;
    int idx;
    is_err  = 1'b0;
    n       = 0;
    err_cyc = 0;
    if (size >= 42) begin
      is_err  = 1'b1;
      err_cyc = 1;
      return;
    end
    total = 0;
    for (int r = 0; r < 4; r++) total += int'(lut_tab[size][r]);
    if (total > 12) begin
      is_err  = 1'b1;
      err_cyc = 6;
      return;
    end
    span = 1;
    idx  = 0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < int'(lut_tab[size][r]); j++) begin
        exp_q.push_back({2'(r), 4'(idx), 12'(span), 1'(idx == total - 1)});
        span = (span * rv[r]) % 4096;
        idx++;
      end
    end
    n = total;
  endtask

  task automatic run_one(input int size, input int mode);
    bit is_err;
    int n;
    int err_cyc;
    int t0;
    int c;
    bit seen;
    bit lut_moved;
    rdy_mode  = mode;
    rdy_phase = 0;
    model(size, is_err, n, err_cyc);
    io_fftsize = 6'(size);
    io_start   = 1'b1;
    t0         = cyc;
    tick();
    io_start   = 1'b0;
    io_fftsize = 6'($urandom_range(0, 63));
    seen       = 1'b0;
    lut_moved  = 1'b0;
    c          = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      c = cyc - t0;
      if (io_lut_power != 3'd0) lut_moved = 1'b1;
      if (io_done || io_err) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      check("outcome_err", 32'(io_err), 32'(is_err));
      check("outcome_done", 32'(io_done), 32'(!is_err));
      if (is_err) check("err_cycle", 32'(c), 32'(err_cyc));
      else if (n == 0) check("done_cycle_empty", 32'(c), 32'd6);
      else if (mode == 0) check("done_cycle", 32'(c), 32'(6 + n));
      if (size >= 42) check("lut_power_idle", 32'(lut_moved), 32'd0);
      if (!is_err) exp_count = n;
      check("stage_count", 32'(io_stage_count), 32'(exp_count));
      tick();
      check("pulse_one_cycle", 32'({io_busy, io_done, io_err}), 32'd0);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(io_busy), 32'd0);
    check({tag, "_valid"}, 32'(io_stage_valid), 32'd0);
    check({tag, "_done_err"}, 32'({io_done, io_err}), 32'd0);
    check({tag, "_lut"}, 32'({io_lut_fftsize, io_lut_power}), 32'd0);
    check({tag, "_fields"}, 32'({io_stage_radix, io_stage_idx, io_stage_span, io_stage_last}), 32'd0);
    check({tag, "_count"}, 32'(io_stage_count), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    reset      = 1'b1;
    io_start   = 1'b0;
    io_abort   = 1'b0;
    io_fftsize = 6'd0;
    for (int s = 0; s < 64; s++)
      for (int r = 0; r < 4; r++) lut_tab[s][r] = 3'($urandom_range(0, 3));
    lut_tab[5]  = '{3'd2, 3'd1, 3'd1, 3'd0};
    lut_tab[7]  = '{3'd0, 3'd0, 3'd0, 3'd0};
    lut_tab[9]  = '{3'd5, 3'd4, 3'd3, 3'd1};
    lut_tab[40] = '{3'd7, 3'd6, 3'd0, 3'd0};
    lut_tab[41] = '{3'd3, 3'd3, 3'd3, 3'd3};
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    run_one(5, 0);
    run_one(5, 1);
    run_one(42, 0);
    run_one(7, 0);
    run_one(9, 0);
    run_one(41, 0);
    run_one(40, 2);
    run_one(41, 1);

    // abort during the second handshake of size 5
    rdy_mode = 0;
    exp_q.push_back({2'd0, 4'd0, 12'd1, 1'b0});
    io_fftsize = 6'd5;
    io_start   = 1'b1;
    t0         = cyc;
    tick();
    io_start = 1'b0;
    repeat (6) tick();
    check("abort_at_cycle", 32'(cyc - t0), 32'd7);
    check("abort_stage_idx", 32'({io_stage_valid, io_stage_idx}), 32'h11);
    io_abort = 1'b1;
    tick();
    io_abort = 1'b0;
    check("abort_idle", 32'({io_busy, io_stage_valid, io_done}), 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_count = 4;
    run_one(5, 0);

    // reset while loading
    io_fftsize = 6'd5;
    io_start   = 1'b1;
    tick();
    io_start = 1'b0;
    tick();
    check("load_busy", 32'(io_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    exp_count = 0;
    check_all_zero("midreset");
    tick();

    for (int t = 0; t < 20; t++) run_one($urandom_range(0, 45), $urandom_range(0, 2));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
